// File: rtl/sd_abort_responder.sv
// rtl/sd_abort_responder.sv - SD card-side CMD12 (STOP_TRANSMISSION) responder with R1b busy on DAT0
module sd_abort_responder #(
  parameter int NCR         = 2,
  parameter int BUSY_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_in,
  input  logic [31:0] card_status,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        dat0_out,
  output logic        dat0_oe,
  output logic        abort_det,
  output logic        crc_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT,
    S_TX,
    S_BUSY,
    S_RELEASE
  } state_e;

  // x^7 + x^3 + 1, taps below the x^7 term
  localparam logic [6:0] CRC_POLY  = 7'h09;
  localparam logic [5:0] CMD_STOP  = 6'd12;
  // WAIT lasts NCR-1 cycles; the registered output stage supplies the last one
  localparam logic [6:0] WAIT_LAST = 7'(NCR - 2);
  localparam int         BW        = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_LAST = BW'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [6:0]    hdr_q, hdr_d;
  logic [7:0]    tail_q, tail_d;
  logic [6:0]    crc_q, crc_d;
  logic [39:0]   tx_sr_q, tx_sr_d;

  logic cmd_out_q, cmd_out_d;
  logic cmd_oe_q, cmd_oe_d;
  logic dat0_out_q, dat0_out_d;
  logic dat0_oe_q, dat0_oe_d;
  logic abort_det_q, abort_det_d;
  logic crc_err_q, crc_err_d;
  logic busy_q, busy_d;
  logic frame_ok;

  // One serial CRC7 step, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ({7{c[6] ^ b}} & CRC_POLY);
  endfunction

  // State, datapath and registered outputs; reset forces every output to its idle value
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_cnt_q  <= '0;
      hdr_q       <= '0;
      tail_q      <= '0;
      crc_q       <= '0;
      tx_sr_q     <= '0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      dat0_out_q  <= 1'b1;
      dat0_oe_q   <= 1'b0;
      abort_det_q <= 1'b0;
      crc_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      hdr_q       <= hdr_d;
      tail_q      <= tail_d;
      crc_q       <= crc_d;
      tx_sr_q     <= tx_sr_d;
      cmd_out_q   <= cmd_out_d;
      cmd_oe_q    <= cmd_oe_d;
      dat0_out_q  <= dat0_out_d;
      dat0_oe_q   <= dat0_oe_d;
      abort_det_q <= abort_det_d;
      crc_err_q   <= crc_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus the output values that appear one edge after the current state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_cnt_d  = busy_cnt_q;
    hdr_d       = hdr_q;
    tail_d      = tail_q;
    crc_d       = crc_q;
    tx_sr_d     = tx_sr_q;
    cmd_out_d   = 1'b1;
    cmd_oe_d    = 1'b0;
    dat0_out_d  = 1'b1;
    dat0_oe_d   = 1'b0;
    abort_det_d = 1'b0;
    crc_err_d   = 1'b0;
    busy_d      = 1'b0;
    frame_ok    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // busy_q is still high for the one cycle after RELEASE; keep the
        // hunter off until busy has visibly dropped
        if (!busy_q && !cmd_in) begin
          state_d = S_RX;
          cnt_d   = 7'd1;
          crc_d   = '0;
        end
      end

      S_RX: begin
        // Only dir+index and the crc/end byte are needed; the argument is
        // consumed by the CRC and otherwise discarded
        tail_d = {tail_q[6:0], cmd_in};
        if (cnt_q <= 7'd7) begin
          hdr_d = {hdr_q[5:0], cmd_in};
        end
        // Start bit is 0 with a zero seed, so it never changes the CRC
        if (cnt_q <= 7'd39) begin
          crc_d = crc7_step(crc_q, cmd_in);
        end
        if (cnt_q == 7'd47) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_CHECK: begin
        frame_ok = hdr_q[6] && (tail_q[7:1] == crc_q) && tail_q[0];
        if (!frame_ok) begin
          crc_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (hdr_q[5:0] == CMD_STOP) begin
          abort_det_d = 1'b1;
          busy_d      = 1'b1;
          tx_sr_d     = {2'b00, CMD_STOP, card_status};
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_TX;
          cnt_d   = '0;
          crc_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_TX: begin
        busy_d   = 1'b1;
        cmd_oe_d = 1'b1;
        if (cnt_q < 7'd40) begin
          cmd_out_d = tx_sr_q[39];
          tx_sr_d   = {tx_sr_q[38:0], 1'b0};
          crc_d     = crc7_step(crc_q, tx_sr_q[39]);
        end else if (cnt_q < 7'd47) begin
          cmd_out_d = crc_q[6];
          crc_d     = {crc_q[5:0], 1'b0};
        end else begin
          cmd_out_d = 1'b1;
        end
        if (cnt_q == 7'd47) begin
          busy_cnt_d = '0;
          state_d    = (BUSY_CYCLES > 0) ? S_BUSY : S_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_BUSY: begin
        busy_d     = 1'b1;
        dat0_oe_d  = 1'b1;
        dat0_out_d = 1'b0;
        if (busy_cnt_q == BUSY_LAST) begin
          state_d = S_RELEASE;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end

      S_RELEASE: begin
        // Actively drive DAT0 high for one cycle before letting go
        busy_d     = 1'b1;
        dat0_oe_d  = 1'b1;
        dat0_out_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_out   = cmd_out_q;
  assign cmd_oe    = cmd_oe_q;
  assign dat0_out  = dat0_out_q;
  assign dat0_oe   = dat0_oe_q;
  assign abort_det = abort_det_q;
  assign crc_err   = crc_err_q;
  assign busy      = busy_q;

endmodule
